// File: rtl/frame_buf_sched_pkg.sv
// Shared types for the triple-buffer scheduler.
// Slot-ownership and FSM encodings plus the slot count.
package frame_buf_sched_pkg;

    localparam int NUM_BUFS = 3;

    typedef logic [1:0] idx_t;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WRITING = 2'd1,
        SLOT_READY   = 2'd2,
        SLOT_READING = 2'd3
    } slot_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fsm_e;

endpackage

// File: rtl/frame_buf_sched_if.sv
// Writer/reader handshake bundle for the frame-buffer scheduler.
// master: capture writer + DMA reader side; slave: scheduler side.
interface frame_buf_sched_if #(
    parameter int ADDR_W = 32
);
    logic              wr_req;
    logic              wr_grant;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_idx;
    logic              wr_done;
    logic              wr_err;

    logic              rd_req;
    logic              rd_grant;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_idx;
    logic              rd_done;

    modport master (
        output wr_req, wr_done, wr_err,
        output rd_req, rd_done,
        input  wr_grant, wr_addr, wr_idx,
        input  rd_grant, rd_addr, rd_idx
    );

    modport slave (
        input  wr_req, wr_done, wr_err,
        input  rd_req, rd_done,
        output wr_grant, wr_addr, wr_idx,
        output rd_grant, rd_addr, rd_idx
    );
endinterface

// File: rtl/frame_buf_sched_sat_counter.sv
// Saturating up-counter used for frame and drop statistics.
// Ports: clk, rst (async), clr (sync), inc, count (holds at all-ones).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/frame_buf_sched.sv
// Triple-buffer scheduler: grants slots to the writer and reader.
// Ports: aclk/areset, cfg_* control, bus handshake, sts_*/evt_*/counters.
module frame_buf_sched
    import frame_buf_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_enable,
    input  logic              cfg_soft_reset,
    input  logic [ADDR_W-1:0] cfg_buf_addr0,
    input  logic [ADDR_W-1:0] cfg_buf_addr1,
    input  logic [ADDR_W-1:0] cfg_buf_addr2,
    frame_buf_sched_if.slave  bus,
    output logic [1:0]        sts_buf_idx,
    output logic              sts_idle,
    output logic              evt_frame_done,
    output logic              evt_error,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    fsm_e              state_q;
    slot_e             slot_q [NUM_BUFS];
    slot_e             slot_d [NUM_BUFS];
    logic [ADDR_W-1:0] slot_addr [NUM_BUFS];

    logic wr_hold, rd_hold;
    idx_t wr_slot, rd_slot;

    logic free_ok, ready_ok;
    idx_t free_idx, ready_idx;
    logic [ADDR_W-1:0] free_addr;

    logic run_ok;
    logic wr_take, rd_take;
    logic wr_fin, wr_abort, rd_fin;
    logic drop, stray, busy_d;

    assign bus.wr_idx = wr_slot;
    assign bus.rd_idx = rd_slot;

    // Downward scan so the lowest matching index wins.
    always_comb begin
        free_ok   = 1'b0;
        free_idx  = '0;
        ready_ok  = 1'b0;
        ready_idx = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_FREE) begin
                free_ok  = 1'b1;
                free_idx = idx_t'(i);
            end
            if (slot_q[i] == SLOT_READY) begin
                ready_ok  = 1'b1;
                ready_idx = idx_t'(i);
            end
        end
    end

    always_comb begin
        unique case (free_idx)
            2'd0:    free_addr = cfg_buf_addr0;
            2'd1:    free_addr = cfg_buf_addr1;
            default: free_addr = cfg_buf_addr2;
        endcase
    end

    assign run_ok   = (state_q == ST_RUN) && cfg_enable;
    assign wr_take  = run_ok && !wr_hold && bus.wr_req && free_ok;
    assign rd_take  = run_ok && !rd_hold && bus.rd_req && ready_ok;
    assign wr_abort = wr_hold && bus.wr_err;
    assign wr_fin   = wr_hold && bus.wr_done && !bus.wr_err;
    assign rd_fin   = rd_hold && bus.rd_done;
    // A READY frame the reader grabs this cycle is not a drop.
    assign drop     = wr_fin && ready_ok && !rd_take;
    assign stray    = (!wr_hold && (bus.wr_done || bus.wr_err))
                   || (!rd_hold && bus.rd_done);

    always_comb begin
        slot_d = slot_q;
        if (rd_take) slot_d[ready_idx] = SLOT_READING;
        if (wr_abort) begin
            slot_d[wr_slot] = SLOT_FREE;
        end else if (wr_fin) begin
            if (drop) slot_d[ready_idx] = SLOT_FREE;
            slot_d[wr_slot] = SLOT_READY;
        end
        if (rd_fin) slot_d[rd_slot] = SLOT_FREE;
        if (wr_take) slot_d[free_idx] = SLOT_WRITING;
        busy_d = 1'b0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (slot_d[i] == SLOT_WRITING || slot_d[i] == SLOT_READING)
                busy_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q        <= ST_IDLE;
            sts_idle       <= 1'b1;
            for (int i = 0; i < NUM_BUFS; i++) begin
                slot_q[i]    <= SLOT_FREE;
                slot_addr[i] <= '0;
            end
            wr_hold        <= 1'b0;
            rd_hold        <= 1'b0;
            wr_slot        <= '0;
            rd_slot        <= '0;
            bus.wr_grant   <= 1'b0;
            bus.rd_grant   <= 1'b0;
            bus.wr_addr    <= '0;
            bus.rd_addr    <= '0;
            sts_buf_idx    <= '0;
            evt_frame_done <= 1'b0;
            evt_error      <= 1'b0;
        end else if (cfg_soft_reset) begin
            state_q        <= ST_IDLE;
            sts_idle       <= 1'b1;
            for (int i = 0; i < NUM_BUFS; i++) begin
                slot_q[i]    <= SLOT_FREE;
                slot_addr[i] <= '0;
            end
            wr_hold        <= 1'b0;
            rd_hold        <= 1'b0;
            wr_slot        <= '0;
            rd_slot        <= '0;
            bus.wr_grant   <= 1'b0;
            bus.rd_grant   <= 1'b0;
            bus.wr_addr    <= '0;
            bus.rd_addr    <= '0;
            sts_buf_idx    <= '0;
            evt_frame_done <= 1'b0;
            evt_error      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        state_q  <= ST_RUN;
                        sts_idle <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!cfg_enable) begin
                        state_q  <= busy_d ? ST_FLUSH : ST_IDLE;
                        sts_idle <= !busy_d;
                    end
                end
                ST_FLUSH: begin
                    if (cfg_enable) begin
                        state_q  <= ST_RUN;
                        sts_idle <= 1'b0;
                    end else if (!busy_d) begin
                        state_q  <= ST_IDLE;
                        sts_idle <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    sts_idle <= 1'b1;
                end
            endcase

            slot_q       <= slot_d;
            bus.wr_grant <= wr_take;
            bus.rd_grant <= rd_take;

            if (wr_take) begin
                wr_hold             <= 1'b1;
                wr_slot             <= free_idx;
                bus.wr_addr         <= free_addr;
                slot_addr[free_idx] <= free_addr;
            end else if (wr_abort || wr_fin) begin
                wr_hold <= 1'b0;
            end

            if (rd_take) begin
                rd_hold     <= 1'b1;
                rd_slot     <= ready_idx;
                bus.rd_addr <= slot_addr[ready_idx];
            end else if (rd_fin) begin
                rd_hold <= 1'b0;
            end

            if (wr_fin) sts_buf_idx <= wr_slot;
            evt_frame_done <= wr_fin;
            evt_error      <= wr_abort || stray;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_frame_cnt (
        .clk   (aclk),
        .rst   (areset),
        .clr   (cfg_soft_reset),
        .inc   (wr_fin),
        .count (frame_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
        .clk   (aclk),
        .rst   (areset),
        .clr   (cfg_soft_reset),
        .inc   (drop),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched plus a narrow sat_counter.
// Expected values are hand-derived for each step.
module tb_frame_buf_sched;
    import frame_buf_sched_pkg::*;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cfg_enable = 1'b0;
    logic        cfg_soft_reset = 1'b0;
    logic [31:0] cfg_buf_addr0 = '0;
    logic [31:0] cfg_buf_addr1 = '0;
    logic [31:0] cfg_buf_addr2 = '0;
    logic [1:0]  sts_buf_idx;
    logic        sts_idle;
    logic        evt_frame_done;
    logic        evt_error;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    logic        sc_clr = 1'b0;
    logic        sc_inc = 1'b0;
    logic [1:0]  sc_count;

    int vectors = 0;
    int errors  = 0;

    frame_buf_sched_if #(.ADDR_W(32)) bus ();

    frame_buf_sched #(.ADDR_W(32), .CNT_W(16)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .cfg_enable     (cfg_enable),
        .cfg_soft_reset (cfg_soft_reset),
        .cfg_buf_addr0  (cfg_buf_addr0),
        .cfg_buf_addr1  (cfg_buf_addr1),
        .cfg_buf_addr2  (cfg_buf_addr2),
        .bus            (bus),
        .sts_buf_idx    (sts_buf_idx),
        .sts_idle       (sts_idle),
        .evt_frame_done (evt_frame_done),
        .evt_error      (evt_error),
        .frame_cnt      (frame_cnt),
        .drop_cnt       (drop_cnt)
    );

    sat_counter #(.WIDTH(2)) u_sc (
        .clk   (aclk),
        .rst   (areset),
        .clr   (sc_clr),
        .inc   (sc_inc),
        .count (sc_count)
    );

    always #5 aclk = ~aclk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [1:0] exp_idx);
        bus.wr_req = 1'b1;
        step();
        chk("frame_grant", 32'(bus.wr_grant), 32'd1);
        chk("frame_idx", 32'(bus.wr_idx), 32'(exp_idx));
        bus.wr_req = 1'b0;
        step();
        bus.wr_done = 1'b1;
        step();
        chk("frame_done_evt", 32'(evt_frame_done), 32'd1);
        bus.wr_done = 1'b0;
        step();
    endtask

    initial begin
        bus.wr_req  = 1'b0;
        bus.wr_done = 1'b0;
        bus.wr_err  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_done = 1'b0;

        // reset state
        step(2);
        chk("rst_wr_grant", 32'(bus.wr_grant), 32'd0);
        chk("rst_rd_grant", 32'(bus.rd_grant), 32'd0);
        chk("rst_idle", 32'(sts_idle), 32'd1);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_wr_addr", bus.wr_addr, 32'd0);
        chk("rst_buf_idx", 32'(sts_buf_idx), 32'd0);
        chk("rst_evt_error", 32'(evt_error), 32'd0);
        areset = 1'b0;
        cfg_buf_addr0 = 32'h1000;
        cfg_buf_addr1 = 32'h2000;
        cfg_buf_addr2 = 32'h3000;
        cfg_enable = 1'b1;
        step();
        chk("run_idle", 32'(sts_idle), 32'd0);

        // first grant and completion
        bus.wr_req = 1'b1;
        step();
        chk("t1_grant", 32'(bus.wr_grant), 32'd1);
        chk("t1_idx", 32'(bus.wr_idx), 32'd0);
        chk("t1_addr", bus.wr_addr, 32'h1000);
        bus.wr_req = 1'b0;
        step();
        chk("t1_grant_pulse", 32'(bus.wr_grant), 32'd0);
        bus.wr_done = 1'b1;
        step();
        chk("t1_done_evt", 32'(evt_frame_done), 32'd1);
        chk("t1_buf_idx", 32'(sts_buf_idx), 32'd0);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        bus.wr_done = 1'b0;
        step();
        chk("t1_done_pulse", 32'(evt_frame_done), 32'd0);

        // soft reset clears the counters
        cfg_soft_reset = 1'b1;
        step();
        chk("sr_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("sr_idle", 32'(sts_idle), 32'd1);
        cfg_soft_reset = 1'b0;
        step();

        // three frames, no reader
        frame(2'd0);
        frame(2'd1);
        frame(2'd0);
        chk("t2_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("t2_buf_idx", 32'(sts_buf_idx), 32'd0);

        // reader holds slot 0 while writer rotates 1 and 2
        bus.rd_req = 1'b1;
        step();
        chk("t3_rd_grant", 32'(bus.rd_grant), 32'd1);
        chk("t3_rd_idx", 32'(bus.rd_idx), 32'd0);
        chk("t3_rd_addr", bus.rd_addr, 32'h1000);
        bus.rd_req = 1'b0;
        step();
        frame(2'd1);
        frame(2'd2);
        chk("t3_rd_idx_held", 32'(bus.rd_idx), 32'd0);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd3);
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd5);
        chk("t3_buf_idx", 32'(sts_buf_idx), 32'd2);
        bus.rd_done = 1'b1;
        step();
        chk("t3_rd_done_noerr", 32'(evt_error), 32'd0);
        bus.rd_done = 1'b0;
        bus.rd_req = 1'b1;
        step();
        chk("t3_rd_grant2", 32'(bus.rd_grant), 32'd1);
        chk("t3_rd_idx2", 32'(bus.rd_idx), 32'd2);
        chk("t3_rd_addr2", bus.rd_addr, 32'h3000);
        bus.rd_req = 1'b0;
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        step();

        // rd_req together with the wr_done that makes READY: N+2
        bus.wr_req = 1'b1;
        step();
        chk("t3b_wr_idx", 32'(bus.wr_idx), 32'd0);
        bus.wr_req = 1'b0;
        step();
        bus.wr_done = 1'b1;
        bus.rd_req = 1'b1;
        step();
        chk("t3b_no_rd_grant", 32'(bus.rd_grant), 32'd0);
        chk("t3b_frame_cnt", 32'(frame_cnt), 32'd6);
        bus.wr_done = 1'b0;
        step();
        chk("t3b_rd_grant", 32'(bus.rd_grant), 32'd1);
        chk("t3b_rd_idx", 32'(bus.rd_idx), 32'd0);
        bus.rd_req = 1'b0;
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;

        // wr_done and rd grant in one cycle: no drop
        frame(2'd0);
        bus.wr_req = 1'b1;
        step();
        chk("t3c_wr_idx", 32'(bus.wr_idx), 32'd1);
        bus.wr_req = 1'b0;
        step();
        bus.wr_done = 1'b1;
        bus.rd_req = 1'b1;
        step();
        chk("t3c_rd_grant", 32'(bus.rd_grant), 32'd1);
        chk("t3c_rd_idx", 32'(bus.rd_idx), 32'd0);
        chk("t3c_drop_cnt", 32'(drop_cnt), 32'd3);
        chk("t3c_frame_cnt", 32'(frame_cnt), 32'd8);
        chk("t3c_buf_idx", 32'(sts_buf_idx), 32'd1);
        bus.wr_done = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        step();

        // writer error, done+err together, stray rd_done
        bus.wr_req = 1'b1;
        step();
        chk("t4_wr_idx", 32'(bus.wr_idx), 32'd0);
        bus.wr_req = 1'b0;
        step();
        bus.wr_err = 1'b1;
        step();
        chk("t4_err_evt", 32'(evt_error), 32'd1);
        chk("t4_err_no_done", 32'(evt_frame_done), 32'd0);
        chk("t4_err_frame_cnt", 32'(frame_cnt), 32'd8);
        bus.wr_err = 1'b0;
        bus.wr_req = 1'b1;
        step();
        chk("t4_regrant", 32'(bus.wr_grant), 32'd1);
        chk("t4_regrant_idx", 32'(bus.wr_idx), 32'd0);
        bus.wr_req = 1'b0;
        step();
        bus.wr_done = 1'b1;
        bus.wr_err = 1'b1;
        step();
        chk("t4_both_err", 32'(evt_error), 32'd1);
        chk("t4_both_no_done", 32'(evt_frame_done), 32'd0);
        chk("t4_both_frame_cnt", 32'(frame_cnt), 32'd8);
        bus.wr_done = 1'b0;
        bus.wr_err = 1'b0;
        bus.rd_done = 1'b1;
        step();
        chk("t4_stray_rd_err", 32'(evt_error), 32'd1);
        chk("t4_stray_frame_cnt", 32'(frame_cnt), 32'd8);
        bus.rd_done = 1'b0;
        step();
        chk("t4_err_pulse", 32'(evt_error), 32'd0);

        // flush while writing
        bus.wr_req = 1'b1;
        step();
        chk("t5_wr_idx", 32'(bus.wr_idx), 32'd0);
        bus.wr_req = 1'b0;
        cfg_enable = 1'b0;
        step();
        chk("t5_flush_idle", 32'(sts_idle), 32'd0);
        bus.rd_req = 1'b1;
        step();
        chk("t5_flush_no_grant", 32'(bus.rd_grant), 32'd0);
        bus.rd_req = 1'b0;
        bus.wr_done = 1'b1;
        step();
        chk("t5_idle", 32'(sts_idle), 32'd1);
        chk("t5_done_evt", 32'(evt_frame_done), 32'd1);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd9);
        chk("t5_drop_cnt", 32'(drop_cnt), 32'd4);
        bus.wr_done = 1'b0;

        // soft reset with both sides holding slots
        cfg_enable = 1'b1;
        step();
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        step();
        chk("t6_wr_grant", 32'(bus.wr_grant), 32'd1);
        chk("t6_wr_idx", 32'(bus.wr_idx), 32'd1);
        chk("t6_rd_grant", 32'(bus.rd_grant), 32'd1);
        chk("t6_rd_idx", 32'(bus.rd_idx), 32'd0);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        step();
        cfg_soft_reset = 1'b1;
        step();
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t6_idle", 32'(sts_idle), 32'd1);
        chk("t6_wr_idx_clr", 32'(bus.wr_idx), 32'd0);
        cfg_soft_reset = 1'b0;
        bus.wr_done = 1'b1;
        step();
        chk("t6_abandon_err", 32'(evt_error), 32'd1);
        chk("t6_abandon_no_done", 32'(evt_frame_done), 32'd0);
        bus.wr_done = 1'b0;
        step();
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        step();
        chk("t6_no_ready", 32'(bus.rd_grant), 32'd0);
        chk("t6_free_grant", 32'(bus.wr_grant), 32'd1);
        chk("t6_free_idx", 32'(bus.wr_idx), 32'd0);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        step();

        // saturation on a 2-bit counter
        sc_clr = 1'b1;
        step();
        sc_clr = 1'b0;
        sc_inc = 1'b1;
        step(2);
        chk("sat_count2", 32'(sc_count), 32'd2);
        step(3);
        chk("sat_hold", 32'(sc_count), 32'd3);
        sc_inc = 1'b0;
        sc_clr = 1'b1;
        step();
        chk("sat_clr", 32'(sc_count), 32'd0);
        sc_clr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
